idex_pipe: RTL and testbench

//  Parametrised ID/EX pipeline register with valid/ready flow control, stall hold,

---
 rtl/idex_pipe.sv | 106 ++++++++++
 tb/tb_idex_pipe.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/idex_pipe.sv
// ID/EX pipeline register: single-entry valid/ready stage with stall hold,
// synchronous flush and load-use bubble insertion with a saturating bubble count.
module idex_pipe #(
    parameter int DATA_W    = 32,
    parameter int REG_W     = 5,
    parameter int CTRL_W    = 8,
    parameter int LOAD_BIT  = 0,
    parameter int USERT_BIT = 1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_busA,
    input  logic [DATA_W-1:0] i_busB,
    input  logic [DATA_W-1:0] i_imm32,
    input  logic [REG_W-1:0]  i_rs,
    input  logic [REG_W-1:0]  i_rt,
    input  logic [REG_W-1:0]  i_rd,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_busA,
    output logic [DATA_W-1:0] o_busB,
    output logic [DATA_W-1:0] o_imm32,
    output logic [REG_W-1:0]  o_rs,
    output logic [REG_W-1:0]  o_rt,
    output logic [REG_W-1:0]  o_rd,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic              o_hazard,
    output logic [CNT_W-1:0]  o_bubble_cnt
);

    typedef struct packed {
        logic [DATA_W-1:0] busA;
        logic [DATA_W-1:0] busB;
        logic [DATA_W-1:0] imm;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
        logic [CTRL_W-1:0] ctrl;
    } payload_t;

    payload_t         pl_q, pl_d, pl_in;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hazard;

    assign pl_in = '{busA: i_busA, busB: i_busB, imm: i_imm32,
                     rs: i_rs, rt: i_rt, rd: i_rd, ctrl: i_ctrl};

    // Held load whose destination feeds the incoming instruction; r0 is never a hazard.
    assign hazard = valid_q & pl_q.ctrl[LOAD_BIT] & (pl_q.rd != '0) & i_valid &
                    ((i_rs == pl_q.rd) | (i_ctrl[USERT_BIT] & (i_rt == pl_q.rd)));

    assign o_ready = (~valid_q | i_ready) & ~hazard;

    always_comb begin
        valid_d = valid_q;
        pl_d    = pl_q;
        cnt_d   = cnt_q;
        if (flush) begin
            valid_d = 1'b0;
            pl_d    = '0;
        end else if (valid_q && !i_ready) begin
            valid_d = valid_q;
        end else if (hazard) begin
            // Load drains to EX; a zero bubble takes its place while ID retries.
            valid_d = 1'b0;
            pl_d    = '0;
            cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        end else if (i_valid) begin
            valid_d = 1'b1;
            pl_d    = pl_in;
        end else begin
            valid_d = 1'b0;
            pl_d    = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pl_q    <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pl_q    <= pl_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_valid      = valid_q;
    assign o_busA       = pl_q.busA;
    assign o_busB       = pl_q.busB;
    assign o_imm32      = pl_q.imm;
    assign o_rs         = pl_q.rs;
    assign o_rt         = pl_q.rt;
    assign o_rd         = pl_q.rd;
    assign o_ctrl       = pl_q.ctrl;
    assign o_hazard     = hazard;
    assign o_bubble_cnt = cnt_q;

endmodule

// File: tb/tb_idex_pipe.sv
// Bench for idex_pipe: directed scenarios with literal expectations, then random
// traffic compared each cycle against a transaction-level model of the held slot.
module tb_idex_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush, i_valid, i_ready;
    logic [31:0] i_busA, i_busB, i_imm32;
    logic [4:0]  i_rs, i_rt, i_rd;
    logic [7:0]  i_ctrl;

    logic        o_ready, o_valid, o_hazard;
    logic [31:0] o_busA, o_busB, o_imm32;
    logic [4:0]  o_rs, o_rt, o_rd;
    logic [7:0]  o_ctrl;
    logic [15:0] o_cnt;

    logic        o2_ready, o2_valid, o2_hazard;
    logic [31:0] o2_busA, o2_busB, o2_imm32;
    logic [4:0]  o2_rs, o2_rt, o2_rd;
    logic [7:0]  o2_ctrl;
    logic [1:0]  o2_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    idex_pipe dut (
        .clk(clk), .rst(rst), .flush(flush), .i_valid(i_valid), .o_ready(o_ready),
        .i_busA(i_busA), .i_busB(i_busB), .i_imm32(i_imm32),
        .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd), .i_ctrl(i_ctrl), .i_ready(i_ready),
        .o_valid(o_valid), .o_busA(o_busA), .o_busB(o_busB), .o_imm32(o_imm32),
        .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_ctrl(o_ctrl),
        .o_hazard(o_hazard), .o_bubble_cnt(o_cnt)
    );

    idex_pipe #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .flush(flush), .i_valid(i_valid), .o_ready(o2_ready),
        .i_busA(i_busA), .i_busB(i_busB), .i_imm32(i_imm32),
        .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd), .i_ctrl(i_ctrl), .i_ready(i_ready),
        .o_valid(o2_valid), .o_busA(o2_busA), .o_busB(o2_busB), .o_imm32(o2_imm32),
        .o_rs(o2_rs), .o_rt(o2_rt), .o_rd(o2_rd), .o_ctrl(o2_ctrl),
        .o_hazard(o2_hazard), .o_bubble_cnt(o2_cnt)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model: one held instruction record ----------------
    typedef struct {
        bit          v;
        logic [31:0] a, b, imm;
        logic [4:0]  rs, rt, rd;
        logic [7:0]  ctrl;
    } rec_t;

    rec_t held;
    int   nbub;   // bubbles inserted since reset, unbounded

    function automatic bit m_hazard();
        bit uses_dest;
        if (!held.v || !held.ctrl[0] || held.rd == 0 || !i_valid) return 0;
        uses_dest = (i_rs == held.rd) || (i_ctrl[1] && i_rt == held.rd);
        return uses_dest;
    endfunction

    function automatic rec_t empty_rec();
        rec_t r;
        r.v = 0; r.a = 0; r.b = 0; r.imm = 0; r.rs = 0; r.rt = 0; r.rd = 0; r.ctrl = 0;
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            held = empty_rec();
            nbub = 0;
        end else if (flush) begin
            held = empty_rec();
        end else if (held.v && !i_ready) begin
            // EX busy: keep the instruction
        end else if (m_hazard()) begin
            held = empty_rec();
            nbub = nbub + 1;
        end else if (i_valid) begin
            held.v = 1; held.a = i_busA; held.b = i_busB; held.imm = i_imm32;
            held.rs = i_rs; held.rt = i_rt; held.rd = i_rd; held.ctrl = i_ctrl;
        end else begin
            held = empty_rec();
        end
    end

    always @(negedge clk) begin
        bit h;
        h = m_hazard();
        chk("valid",  64'(o_valid),  64'(held.v));
        chk("busA",   64'(o_busA),   64'(held.a));
        chk("busB",   64'(o_busB),   64'(held.b));
        chk("imm",    64'(o_imm32),  64'(held.imm));
        chk("rs",     64'(o_rs),     64'(held.rs));
        chk("rt",     64'(o_rt),     64'(held.rt));
        chk("rd",     64'(o_rd),     64'(held.rd));
        chk("ctrl",   64'(o_ctrl),   64'(held.ctrl));
        chk("hazard", 64'(o_hazard), 64'(h));
        chk("ready",  64'(o_ready),  64'((!held.v || i_ready) && !h));
        chk("cnt16",  64'(o_cnt),    64'(nbub > 65535 ? 65535 : nbub));
        chk("cnt2",   64'(o2_cnt),   64'(nbub > 3 ? 3 : nbub));
    end

    // ---------------- directed + random stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic [7:0] c);
        i_valid = v; i_busA = a; i_busB = ~a; i_imm32 = a + 32'd7;
        i_rs = rs; i_rt = rt; i_rd = rd; i_ctrl = c;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; i_ready = 1'b1;
        drive(1'b1, 32'h1234, 5'd0, 5'd0, 5'd0, 8'h00);

        // Reset holds the stage empty even with valid input
        tick(); tick();
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_busA",  64'(o_busA),  64'd0);
        chk("rst_cnt",   64'(o_cnt),   64'd0);
        #3 rst = 1'b0;
        tick();
        chk("first_valid", 64'(o_valid), 64'd1);
        chk("first_busA",  64'(o_busA),  64'h1234);

        // Back-to-back stream
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 32'(k), 5'd0, 5'd0, 5'(k), 8'h00);
            tick();
            chk("stream_rd", 64'(o_rd), 64'(k));
        end

        // Stall
        drive(1'b1, 32'hAA, 5'd0, 5'd0, 5'd5, 8'h00);
        tick();
        chk("stall_load", 64'(o_busA), 64'hAA);
        i_ready = 1'b0;
        drive(1'b1, 32'hBB, 5'd0, 5'd0, 5'd6, 8'h00);
        for (int k = 0; k < 3; k++) begin
            #1 chk("stall_ready", 64'(o_ready), 64'd0);
            tick();
            chk("stall_hold", 64'(o_busA), 64'hAA);
        end
        i_ready = 1'b1;
        tick();
        chk("stall_release", 64'(o_busA), 64'hBB);

        // Load-use hazard
        drive(1'b1, 32'h11, 5'd0, 5'd0, 5'd8, 8'h01);
        tick();
        drive(1'b1, 32'h22, 5'd8, 5'd0, 5'd9, 8'h00);
        #1;
        chk("lu_hazard", 64'(o_hazard), 64'd1);
        chk("lu_ready",  64'(o_ready),  64'd0);
        tick();
        chk("lu_bubble", 64'(o_valid), 64'd0);
        chk("lu_cnt",    64'(o_cnt),   64'd1);
        tick();
        chk("lu_retry_v",  64'(o_valid), 64'd1);
        chk("lu_retry_rd", 64'(o_rd),    64'd9);
        drive(1'b1, 32'h33, 5'd0, 5'd0, 5'd0, 8'h01);
        tick();
        drive(1'b1, 32'h44, 5'd0, 5'd0, 5'd10, 8'h00);
        #1 chk("lu_r0_nohaz", 64'(o_hazard), 64'd0);

        // Flush
        flush = 1'b1;
        drive(1'b1, 32'h55, 5'd0, 5'd0, 5'd11, 8'h04);
        tick();
        chk("fl_valid", 64'(o_valid), 64'd0);
        chk("fl_ctrl",  64'(o_ctrl),  64'd0);
        chk("fl_cnt",   64'(o_cnt),   64'd1);
        flush = 1'b0;
        drive(1'b1, 32'h66, 5'd0, 5'd0, 5'd8, 8'h01);
        tick();
        drive(1'b1, 32'h77, 5'd8, 5'd0, 5'd12, 8'h00);
        flush = 1'b1;
        #1 chk("fl_haz", 64'(o_hazard), 64'd1);
        tick();
        chk("flh_valid", 64'(o_valid), 64'd0);
        chk("flh_cnt",   64'(o_cnt),   64'd1);
        flush = 1'b0;

        // Five more hazards: 2-bit counter pins at 3
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 32'h80, 5'd0, 5'd0, 5'd8, 8'h01);
            tick();
            drive(1'b1, 32'h81, 5'd1, 5'd8, 5'd2, 8'h02);
            tick();
        end
        chk("sat_cnt2",  64'(o2_cnt), 64'd3);
        chk("sat_cnt16", 64'(o_cnt),  64'd6);

        // Random traffic over a tiny register space so hazards are frequent
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(3) != 0, $urandom, 5'($urandom_range(3)),
                  5'($urandom_range(3)), 5'($urandom_range(3)), 8'($urandom));
            i_ready = $urandom_range(3) != 0;
            flush   = $urandom_range(15) == 0;
            if (n == 1500) begin
                #2 rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
